// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : axis_sync_fifo
// Purpose  : AXI4-Stream beat FIFO with a registered FWFT output stage and an
//            optional store-and-forward packet mode.
// Revision : 1.0
// ============================================================================
module axis_sync_fifo #(
    parameter int TDATA_WIDTH          = 2,
    parameter int TID_WIDTH            = 1,
    parameter int TDEST_WIDTH          = 1,
    parameter int TUSER_WIDTH_PER_BYTE = 1,
    parameter int DEPTH                = 16,
    parameter int PACKET_MODE          = 0
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,

    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic [TDATA_WIDTH*8-1:0]                  s_axis_tdata,
    input  logic [TDATA_WIDTH-1:0]                    s_axis_tstrb,
    input  logic [TDATA_WIDTH-1:0]                    s_axis_tkeep,
    input  logic                                      s_axis_tlast,
    input  logic [TID_WIDTH-1:0]                      s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]                    s_axis_tdest,
    input  logic [TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] s_axis_tuser,

    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [TDATA_WIDTH*8-1:0]                  m_axis_tdata,
    output logic [TDATA_WIDTH-1:0]                    m_axis_tstrb,
    output logic [TDATA_WIDTH-1:0]                    m_axis_tkeep,
    output logic                                      m_axis_tlast,
    output logic [TID_WIDTH-1:0]                      m_axis_tid,
    output logic [TDEST_WIDTH-1:0]                    m_axis_tdest,
    output logic [TDATA_WIDTH*TUSER_WIDTH_PER_BYTE-1:0] m_axis_tuser,

    output logic [$clog2(DEPTH):0]                    data_count,
    output logic                                      overflow_drop
);

    localparam int DW        = TDATA_WIDTH * 8;
    localparam int UW        = TDATA_WIDTH * TUSER_WIDTH_PER_BYTE;
    localparam int BW        = DW + 2 * TDATA_WIDTH + 1 + TID_WIDTH + TDEST_WIDTH + UW;
    localparam int LAST_POS  = UW + TDEST_WIDTH + TID_WIDTH;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;

    localparam logic [AW-1:0] PTR_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] RAM_FULL = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam bit            PKT      = (PACKET_MODE != 0);

    generate
        if ((DEPTH < 4) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("axis_sync_fifo: DEPTH must be a power of two in 4..4096");
        end
        if ((TDATA_WIDTH < 1) || (TDATA_WIDTH > 512)) begin : g_bad_tdata
            $error("axis_sync_fifo: TDATA_WIDTH must be in 1..512");
        end
    endgenerate

    logic [BW-1:0] mem_q [RAM_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] ram_cnt_q, ram_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pkts_q, pkts_d;
    logic          m_valid_q, m_valid_d;
    logic [BW-1:0] m_beat_q, m_beat_d;
    logic          s_ready_q, s_ready_d;
    logic          forced_q, forced_d;
    logic          ovf_q, ovf_d;

    logic [BW-1:0] w_s_beat;
    logic [BW-1:0] w_head;
    logic          w_accept;
    logic          w_out_hs;
    logic          w_out_free;
    logic          w_make_room;
    logic          w_release;
    logic          w_load;
    logic          w_load_last;

    assign w_s_beat = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                       s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign w_head   = mem_q[rd_ptr_q];

    assign w_accept   = s_axis_tvalid & s_ready_q;
    assign w_out_hs   = m_valid_q & m_axis_tready;
    assign w_out_free = ~m_valid_q | m_axis_tready;

    // A held (unreleased) store can be full with the output stage still empty;
    // an incoming beat then pushes the head into the output stage to make room.
    assign w_make_room = (ram_cnt_q == RAM_FULL) & ~m_valid_q & w_accept;
    assign w_release   = ~PKT | (pkts_q != '0) | forced_q | w_make_room;
    assign w_load      = w_out_free & (ram_cnt_q != '0) & w_release;
    assign w_load_last = w_load & w_head[LAST_POS];

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= w_s_beat;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        count_d   = count_q;
        pkts_d    = pkts_q;
        m_valid_d = m_valid_q;
        m_beat_d  = m_beat_q;
        forced_d  = forced_q;
        ovf_d     = 1'b0;

        if (w_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (w_load) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        case ({w_accept, w_load})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        case ({w_accept, w_out_hs})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (w_load) begin
            m_valid_d = 1'b1;
            m_beat_d  = w_head;
        end else if (w_out_hs) begin
            m_valid_d = 1'b0;
        end

        if (PKT) begin
            case ({w_accept & s_axis_tlast, w_load_last})
                2'b10:   pkts_d = pkts_q + CNT_ONE;
                2'b01:   pkts_d = pkts_q - CNT_ONE;
                default: pkts_d = pkts_q;
            endcase

            // Store completely full with no packet end inside: stream the
            // current packet out rather than deadlock.
            if (forced_q && w_load_last) begin
                forced_d = 1'b0;
            end else if (!forced_q && (count_d == CNT_FULL) && (pkts_d == '0)) begin
                forced_d = 1'b1;
                ovf_d    = 1'b1;
            end
        end

        s_ready_d = (count_d < CNT_FULL);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            count_q   <= '0;
            pkts_q    <= '0;
            m_valid_q <= 1'b0;
            m_beat_q  <= '0;
            s_ready_q <= 1'b0;
            forced_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            count_q   <= count_d;
            pkts_q    <= pkts_d;
            m_valid_q <= m_valid_d;
            m_beat_q  <= m_beat_d;
            s_ready_q <= s_ready_d;
            forced_q  <= forced_d;
            ovf_q     <= ovf_d;
        end
    end

    assign s_axis_tready = s_ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = m_beat_q;
    assign data_count    = count_q;
    assign overflow_drop = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sync_fifo
// Purpose  : Directed self-checking bench; one streaming and one packet-mode FIFO.
// Revision : 1.0
// ============================================================================
module tb_axis_sync_fifo;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic        s0_valid, s0_ready, s0_last, s0_id, s0_dest;
    logic [15:0] s0_data;
    logic [1:0]  s0_strb, s0_keep, s0_user;
    logic        m0_valid, m0_ready, m0_last, m0_id, m0_dest;
    logic [15:0] m0_data;
    logic [1:0]  m0_strb, m0_keep, m0_user;
    logic [4:0]  cnt0;
    logic        ovf0;

    logic        s1_valid, s1_ready, s1_last, s1_id, s1_dest;
    logic [15:0] s1_data;
    logic [1:0]  s1_strb, s1_keep, s1_user;
    logic        m1_valid, m1_ready, m1_last, m1_id, m1_dest;
    logic [15:0] m1_data;
    logic [1:0]  m1_strb, m1_keep, m1_user;
    logic [3:0]  cnt1;
    logic        ovf1;

    int n_tests = 0;
    int n_fail  = 0;

    axis_sync_fifo #(
        .TDATA_WIDTH(2), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_WIDTH_PER_BYTE(1), .DEPTH(16), .PACKET_MODE(0)
    ) u_dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready), .s_axis_tdata(s0_data),
        .s_axis_tstrb(s0_strb), .s_axis_tkeep(s0_keep), .s_axis_tlast(s0_last),
        .s_axis_tid(s0_id), .s_axis_tdest(s0_dest), .s_axis_tuser(s0_user),
        .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready), .m_axis_tdata(m0_data),
        .m_axis_tstrb(m0_strb), .m_axis_tkeep(m0_keep), .m_axis_tlast(m0_last),
        .m_axis_tid(m0_id), .m_axis_tdest(m0_dest), .m_axis_tuser(m0_user),
        .data_count(cnt0), .overflow_drop(ovf0)
    );

    axis_sync_fifo #(
        .TDATA_WIDTH(2), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_WIDTH_PER_BYTE(1), .DEPTH(8), .PACKET_MODE(1)
    ) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready), .s_axis_tdata(s1_data),
        .s_axis_tstrb(s1_strb), .s_axis_tkeep(s1_keep), .s_axis_tlast(s1_last),
        .s_axis_tid(s1_id), .s_axis_tdest(s1_dest), .s_axis_tuser(s1_user),
        .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready), .m_axis_tdata(m1_data),
        .m_axis_tstrb(m1_strb), .m_axis_tkeep(m1_keep), .m_axis_tlast(m1_last),
        .m_axis_tid(m1_id), .m_axis_tdest(m1_dest), .m_axis_tuser(m1_user),
        .data_count(cnt1), .overflow_drop(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int acc;
        int rd;
        int pulses;
        int maxc;

        aresetn  = 1'b1;
        s0_valid = 1'b0; s0_data = '0; s0_strb = 2'b11; s0_keep = 2'b11; s0_last = 1'b0;
        s0_id    = 1'b0; s0_dest = 1'b0; s0_user = '0; m0_ready = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_strb = 2'b11; s1_keep = 2'b11; s1_last = 1'b0;
        s1_id    = 1'b0; s1_dest = 1'b0; s1_user = '0; m1_ready = 1'b0;

        // ---- reset state ----
        #1 aresetn = 1'b0;
        #1;
        chk("rst_s_ready0", s0_ready, 1'b0);
        chk("rst_m_valid0", m0_valid, 1'b0);
        chk("rst_count0",   cnt0, 0);
        chk("rst_mdata0",   m0_data, 0);
        chk("rst_s_ready1", s1_ready, 1'b0);
        chk("rst_ovf1",     ovf1, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_hold_ready0", s0_ready, 1'b0);
        #2 aresetn = 1'b1;
        tick();
        chk("rel_s_ready0", s0_ready, 1'b1);
        chk("rel_s_ready1", s1_ready, 1'b1);

        // ---- passthrough, one cycle latency ----
        m0_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i < 11) begin
                s0_valid = 1'b1;
                s0_data  = 16'(i);
                s0_keep  = (i == 10) ? 2'b10 : 2'b11;
                s0_last  = (i == 10);
                s0_user  = (i == 10) ? 2'b10 : 2'b00;
                s0_id    = (i == 10);
                s0_dest  = (i == 10);
            end else begin
                s0_valid = 1'b0;
            end
            tick();
            if (i >= 1 && i <= 11) begin
                chk("pt_valid", m0_valid, 1'b1);
                chk("pt_data",  m0_data, i - 1);
                chk("pt_keep",  m0_keep, (i == 11) ? 2'b10 : 2'b11);
                chk("pt_last",  m0_last, (i == 11));
                chk("pt_user",  m0_user, (i == 11) ? 2'b10 : 2'b00);
                chk("pt_id",    m0_id,   (i == 11));
                chk("pt_dest",  m0_dest, (i == 11));
            end else if (i == 12) begin
                chk("pt_idle_valid", m0_valid, 1'b0);
                chk("pt_idle_count", cnt0, 0);
            end
        end
        s0_keep = 2'b11; s0_last = 1'b0; s0_user = '0; s0_id = 1'b0; s0_dest = 1'b0;

        // ---- fill to full with sink stalled ----
        m0_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            s0_valid = 1'b1;
            s0_data  = 16'(100 + acc);
            if (s0_valid && s0_ready) acc++;
            tick();
            chk("full_ready", s0_ready, (acc < 16));
        end
        chk("full_accepted", acc, 16);
        chk("full_count",    cnt0, 16);
        chk("full_m_valid",  m0_valid, 1'b1);
        chk("full_m_data",   m0_data, 100);

        // ---- drain with input resuming ----
        m0_ready = 1'b1;
        rd = 0;
        for (int i = 0; i < 40; i++) begin
            s0_valid = (acc < 24);
            s0_data  = 16'(100 + acc);
            if (m0_valid && m0_ready) begin
                chk("drain_data", m0_data, 100 + rd);
                rd++;
            end
            if (s0_valid && s0_ready) acc++;
            tick();
            if (i == 0) begin
                chk("resume_ready", s0_ready, 1'b1);
                chk("resume_count", cnt0, 15);
            end
        end
        chk("drain_reads", rd, 24);
        chk("drain_count", cnt0, 0);

        // ---- simultaneous read/write at count 8 ----
        m0_ready = 1'b0;
        acc = 0;
        rd  = 0;
        for (int i = 0; i < 8; i++) begin
            s0_valid = 1'b1;
            s0_data  = 16'(200 + acc);
            if (s0_valid && s0_ready) acc++;
            tick();
        end
        chk("sim_fill_count", cnt0, 8);
        m0_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s0_valid = 1'b1;
            s0_data  = 16'(200 + acc);
            if (m0_valid && m0_ready) begin
                chk("sim_data", m0_data, 200 + rd);
                rd++;
            end
            if (s0_valid && s0_ready) acc++;
            tick();
            chk("sim_count", cnt0, 8);
        end
        s0_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m0_valid && m0_ready) begin
                chk("sim_tail_data", m0_data, 200 + rd);
                rd++;
            end
            tick();
        end
        chk("sim_reads",    rd, 108);
        chk("sim_accepted", acc, 108);
        chk("sim_empty",    cnt0, 0);

        // ---- packet mode: held until tlast ----
        m1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1_valid = 1'b1;
            s1_data  = 16'(300 + i);
            s1_last  = 1'b0;
            tick();
            chk("pkt_hold", m1_valid, 1'b0);
        end
        s1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pkt_stall", m1_valid, 1'b0);
        end
        chk("pkt_count", cnt1, 4);
        s1_valid = 1'b1;
        s1_data  = 16'(304);
        s1_last  = 1'b1;
        tick();
        chk("pkt_last_accept", m1_valid, 1'b0);
        s1_valid = 1'b0;
        s1_last  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("pkt_valid", m1_valid, 1'b1);
            chk("pkt_data",  m1_data, 300 + j);
            chk("pkt_tlast", m1_last, (j == 4));
        end
        tick();
        chk("pkt_empty", m1_valid, 1'b0);

        // ---- packet mode overflow: 12-beat packet into 8 beats ----
        acc = 0; rd = 0; pulses = 0; maxc = 0;
        for (int i = 0; i < 40; i++) begin
            s1_valid = (acc < 12);
            s1_data  = 16'(400 + acc);
            s1_last  = (acc == 11);
            if (m1_valid && m1_ready) begin
                chk("ovf_data",  m1_data, 400 + rd);
                chk("ovf_tlast", m1_last, (rd == 11));
                rd++;
            end
            if (s1_valid && s1_ready) acc++;
            tick();
            if (ovf1) begin
                pulses++;
                chk("ovf_at_full", cnt1, 8);
            end
            if (int'(cnt1) > maxc) maxc = int'(cnt1);
        end
        s1_valid = 1'b0;
        s1_last  = 1'b0;
        chk("ovf_pulses",   pulses, 1);
        chk("ovf_maxcount", maxc, 8);
        chk("ovf_reads",    rd, 12);
        chk("ovf_empty",    cnt1, 0);

        // ---- asynchronous reset with data stored ----
        m0_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s0_valid = 1'b1;
            s0_data  = 16'(500 + i);
            tick();
        end
        s0_valid = 1'b0;
        tick();
        chk("pre_rst_count", cnt0, 6);
        chk("pre_rst_valid", m0_valid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_valid", m0_valid, 1'b0);
        chk("arst_count", cnt0, 0);
        chk("arst_ready", s0_ready, 1'b0);
        chk("arst_data",  m0_data, 0);
        #2 aresetn = 1'b1;
        m0_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle",  m0_valid, 1'b0);
            chk("post_rst_count", cnt0, 0);
        end
        s0_valid = 1'b1;
        s0_data  = 16'h0055;
        tick();
        s0_valid = 1'b0;
        tick();
        chk("post_rst_valid", m0_valid, 1'b1);
        chk("post_rst_data",  m0_data, 16'h0055);
        tick();
        chk("post_rst_drain", cnt0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
